// File: rtl/n64a_vdemux_auto_pkg.sv
// Shared constants and helpers for the self-phasing N64 VD bus demultiplexer.
// Imported by the interface, the phase counter and the top.
package n64a_vdemux_auto_pkg;

   localparam int unsigned DefColorW  = 7;
   localparam int unsigned DefNch     = 3;
   localparam int unsigned DefSyncW   = 4;
   localparam int unsigned DefDropLsb = 2;

   // Classification of the current VD bus cycle relative to the phase counter.
   typedef enum logic [1:0] {
      CycSync,
      CycColour,
      CycExtra
   } cyc_kind_e;

   function automatic int unsigned cnt_width(input int unsigned nch);
      return $clog2(nch + 1);
   endfunction

endpackage

// File: rtl/n64a_vdemux_auto_if.sv
// VD bus side and pixel output side of the demultiplexer.
// The master drives the bus and the mode pins; the slave is the demux.
interface n64a_vdemux_auto_if
   import n64a_vdemux_auto_pkg::*;
#(
   parameter int unsigned COLOR_W = DefColorW,
   parameter int unsigned NCH     = DefNch,
   parameter int unsigned SYNC_W  = DefSyncW
);
   logic                          nVDSYNC;
   logic [COLOR_W-1:0]            VD_i;
   logic                          vmode_i;
   logic                          ndo_deblur_i;
   logic                          n15bit_mode_i;
   logic [SYNC_W-1:0]             vdata_sy_0_o;
   logic [SYNC_W+NCH*COLOR_W-1:0] vdata_o;
   logic                          vdata_valid_o;
   logic                          phase_err_o;

   modport master (
      output nVDSYNC, VD_i, vmode_i, ndo_deblur_i, n15bit_mode_i,
      input  vdata_sy_0_o, vdata_o, vdata_valid_o, phase_err_o
   );

   modport slave (
      input  nVDSYNC, VD_i, vmode_i, ndo_deblur_i, n15bit_mode_i,
      output vdata_sy_0_o, vdata_o, vdata_valid_o, phase_err_o
   );
endinterface

// File: rtl/n64a_vdemux_phasecnt.sv
// Colour phase counter derived from nVDSYNC: tracks which channel is on the bus,
// flags a complete pixel and raises a one-cycle phase error for malformed pixels.
module n64a_vdemux_phasecnt
   import n64a_vdemux_auto_pkg::*;
#(
   parameter int unsigned NCH = DefNch
) (
   input  logic                       VCLK,
   input  logic                       nRST,
   input  logic                       nvdsync_i,
   output logic [cnt_width(NCH)-1:0]  cnt_o,
   output logic                       capture_o,
   output logic                       complete_o,
   output logic                       phase_err_o
);
   localparam int unsigned     CntW   = cnt_width(NCH);
   localparam logic [CntW-1:0] CntMax = CntW'(NCH);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            complete_q, complete_d;
   logic            no_sync_yet_q, no_sync_yet_d;
   logic            err_q, err_d;
   cyc_kind_e       kind;

   always_comb begin
      if (!nvdsync_i) begin
         kind = CycSync;
      end else if (cnt_q != CntMax) begin
         kind = CycColour;
      end else begin
         kind = CycExtra;
      end
   end

   always_comb begin
      cnt_d         = cnt_q;
      complete_d    = complete_q;
      no_sync_yet_d = no_sync_yet_q;
      err_d         = 1'b0;
      unique case (kind)
         CycSync: begin
            cnt_d         = '0;
            complete_d    = 1'b0;
            no_sync_yet_d = 1'b0;
            // The sync that ends a partial pixel left over from reset is not an error.
            err_d         = !complete_q && !no_sync_yet_q;
         end
         CycColour: begin
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CntMax - CntW'(1)) begin
               complete_d = 1'b1;
            end
         end
         CycExtra: err_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge VCLK or negedge nRST) begin
      if (!nRST) begin
         cnt_q         <= '0;
         complete_q    <= 1'b0;
         no_sync_yet_q <= 1'b1;
         err_q         <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         complete_q    <= complete_d;
         no_sync_yet_q <= no_sync_yet_d;
         err_q         <= err_d;
      end
   end

   assign cnt_o       = cnt_q;
   assign capture_o   = (kind == CycColour);
   assign complete_o  = complete_q;
   assign phase_err_o = err_q;

endmodule

// File: rtl/n64a_vdemux_auto.sv
// Self-phasing VD bus demultiplexer: captures NCH colour words per pixel, applies
// LSB truncation and deblur blanking, and emits the pixel on the following sync cycle.
module n64a_vdemux_auto
   import n64a_vdemux_auto_pkg::*;
#(
   parameter int unsigned COLOR_W  = DefColorW,
   parameter int unsigned NCH      = DefNch,
   parameter int unsigned SYNC_W   = DefSyncW,
   parameter int unsigned DROP_LSB = DefDropLsb
) (
   input logic                VCLK,
   input logic                nRST,
   n64a_vdemux_auto_if.slave  vd_if
);
   localparam int unsigned        CntW = cnt_width(NCH);
   localparam int unsigned        OutW = SYNC_W + NCH * COLOR_W;
   localparam logic [COLOR_W-1:0] TruncMask = {{(COLOR_W - DROP_LSB){1'b1}}, {DROP_LSB{1'b0}}};

   logic [CntW-1:0] cnt;
   logic            capture;
   logic            complete;
   logic            phase_err;

   logic [NCH-1:0][COLOR_W-1:0] ch_q, ch_d;
   logic [SYNC_W-1:0]           sync0_q, sync0_d;
   logic [OutW-1:0]             vdata_q, vdata_d;
   logic                        valid_q, valid_d;
   logic                        nblank_q, nblank_d;
   logic [COLOR_W-1:0]          colour_in;

   n64a_vdemux_phasecnt #(
      .NCH (NCH)
   ) u_phasecnt (
      .VCLK        (VCLK),
      .nRST        (nRST),
      .nvdsync_i   (vd_if.nVDSYNC),
      .cnt_o       (cnt),
      .capture_o   (capture),
      .complete_o  (complete),
      .phase_err_o (phase_err)
   );

   assign colour_in = vd_if.n15bit_mode_i ? vd_if.VD_i : (vd_if.VD_i & TruncMask);

   always_comb begin
      ch_d     = ch_q;
      sync0_d  = sync0_q;
      vdata_d  = vdata_q;
      valid_d  = 1'b0;
      nblank_d = nblank_q;

      for (int i = 0; i < NCH; i++) begin
         if (capture && (cnt == CntW'(i))) begin
            ch_d[i] = colour_in;
         end
      end

      if (!vd_if.nVDSYNC) begin
         sync0_d = vd_if.VD_i[SYNC_W-1:0];
         if (complete) begin
            valid_d                       = 1'b1;
            vdata_d[OutW-1 -: SYNC_W]     = sync0_q;
            // ch0 occupies the most significant colour slot.
            if (nblank_q) begin
               for (int i = 0; i < NCH; i++) begin
                  vdata_d[(NCH - 1 - i) * COLOR_W +: COLOR_W] = ch_q[i];
               end
            end
         end
         if (vd_if.ndo_deblur_i) begin
            nblank_d = 1'b1;
         end else if (!sync0_q[0] && vd_if.VD_i[0]) begin
            nblank_d = vd_if.vmode_i;
         end else begin
            nblank_d = !nblank_q;
         end
      end
   end

   always_ff @(posedge VCLK or negedge nRST) begin
      if (!nRST) begin
         ch_q     <= '0;
         sync0_q  <= '0;
         vdata_q  <= '0;
         valid_q  <= 1'b0;
         nblank_q <= 1'b1;
      end else begin
         ch_q     <= ch_d;
         sync0_q  <= sync0_d;
         vdata_q  <= vdata_d;
         valid_q  <= valid_d;
         nblank_q <= nblank_d;
      end
   end

   assign vd_if.vdata_sy_0_o  = sync0_q;
   assign vd_if.vdata_o       = vdata_q;
   assign vd_if.vdata_valid_o = valid_q;
   assign vd_if.phase_err_o   = phase_err;

endmodule
